// File: rtl/bpred_wr_ctrl.sv
// -----------------------------------------------------------------------------
// bpred_wr_ctrl
//
// Write-port controller for the branch predictor's combined BTB/bimodal table.
// After reset, or when init_req is pulsed, it sweeps every table entry to zero.
// Once the sweep is done it shares the table's single write port between two
// sources:
//   - execute-stage predictor updates, buffered in a small FIFO
//   - a debug/configuration writer using a valid/ready handshake
// The lookup port of the table is not touched here.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   stall                     pipeline stall; blocks update pushes only
//   init_req                  single-cycle pulse requesting a table clear
//   up_valid/index/data/byteen    execute update
//   dbg_valid/index/data/byteen   debug write request, held until accepted
//   dbg_ready                 debug request accepted this cycle (combinational)
//   init_busy                 clear sweep in progress
//   mem_wren/wraddr/data/byteen   registered table write port
//   drop_count                updates lost to FIFO overflow (saturating)
// -----------------------------------------------------------------------------
module bpred_wr_ctrl #(
  parameter int DEPTH      = 256,
  parameter int INDEX_W    = 8,
  parameter int DATA_W     = 36,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               init_req,
  input  logic               up_valid,
  input  logic [INDEX_W-1:0] up_index,
  input  logic [DATA_W-1:0]  up_data,
  input  logic [3:0]         up_byteen,
  input  logic               dbg_valid,
  input  logic [INDEX_W-1:0] dbg_index,
  input  logic [DATA_W-1:0]  dbg_data,
  input  logic [3:0]         dbg_byteen,
  output logic               dbg_ready,
  output logic               init_busy,
  output logic               mem_wren,
  output logic [INDEX_W-1:0] mem_wraddr,
  output logic [DATA_W-1:0]  mem_data,
  output logic [3:0]         mem_byteen,
  output logic [15:0]        drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE = 1;
  localparam logic [INDEX_W-1:0] IDX_ONE  = 1;
  localparam logic [INDEX_W-1:0] IDX_LAST = INDEX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic {GRANT_FIFO, GRANT_DBG} grant_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [INDEX_W-1:0] r_init_idx;
  grant_t             r_last_grant;
  logic [15:0]        r_drop_count;

  logic               r_mem_wren;
  logic [INDEX_W-1:0] r_mem_wraddr;
  logic [DATA_W-1:0]  r_mem_data;
  logic [3:0]         r_mem_byteen;

  // Update FIFO: storage plus pointers carrying one extra wrap bit so that
  // full and empty are distinguishable without a separate counter.
  logic [INDEX_W-1:0] r_fifo_index  [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_fifo_data   [FIFO_DEPTH];
  logic [3:0]         r_fifo_byteen [FIFO_DEPTH];
  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;

  // ---------------------------------------------------------------------------
  // FIFO status and arbitration
  // ---------------------------------------------------------------------------
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic [PTR_W-1:0] w_rd_addr;
  logic [PTR_W-1:0] w_wr_addr;
  logic             w_arb_en;
  logic             w_tie;
  logic             w_grant_dbg;
  logic             w_grant_fifo;
  logic             w_push;
  logic             w_push_ok;
  logic             w_drop;

  assign w_rd_addr    = r_rd_ptr[PTR_W-1:0];
  assign w_wr_addr    = r_wr_ptr[PTR_W-1:0];
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (w_wr_addr == w_rd_addr);

  // Arbitration only happens in RUN when no clear is being requested.
  assign w_arb_en = (r_state == ST_RUN) && !init_req;
  assign w_tie    = w_arb_en && dbg_valid && !w_fifo_empty;

  // last_grant records the winner of the last contested cycle only, so
  // uncontested wins never disturb the alternation between the two sources.
  assign w_grant_dbg  = w_arb_en && dbg_valid &&
                        (w_fifo_empty || (r_last_grant == GRANT_FIFO));
  assign w_grant_fifo = w_arb_en && !w_fifo_empty && !w_grant_dbg;

  // A push into a full FIFO still succeeds if the head leaves on the same edge.
  assign w_push    = w_arb_en && up_valid && !stall;
  assign w_push_ok = w_push && (!w_fifo_full || w_grant_fifo);
  assign w_drop    = w_push && w_fifo_full && !w_grant_fifo;

  // ---------------------------------------------------------------------------
  // Next-state and write-port selection
  // ---------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic [INDEX_W-1:0] w_init_idx_nxt;
  logic               w_flush;
  logic               w_wren_nxt;
  logic [INDEX_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0]  w_data_nxt;
  logic [3:0]         w_byteen_nxt;

  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path through the case leaves one unassigned and a latch is inferred.
    w_state_nxt    = r_state;
    w_init_idx_nxt = r_init_idx;
    w_flush        = 1'b0;
    w_wren_nxt     = 1'b0;
    w_addr_nxt     = r_mem_wraddr;
    w_data_nxt     = r_mem_data;
    w_byteen_nxt   = r_mem_byteen;

    unique case (r_state)
      ST_INIT: begin
        w_wren_nxt   = 1'b1;
        w_addr_nxt   = r_init_idx;
        w_data_nxt   = '0;
        w_byteen_nxt = 4'hF;
        if (init_req) begin
          w_init_idx_nxt = '0;
        end else begin
          // Index wraps back to zero naturally after DEPTH-1.
          w_init_idx_nxt = r_init_idx + IDX_ONE;
          if (r_init_idx == IDX_LAST) w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (init_req) begin
          w_state_nxt    = ST_INIT;
          w_init_idx_nxt = '0;
          w_flush        = 1'b1;
        end else if (w_grant_dbg) begin
          w_wren_nxt   = 1'b1;
          w_addr_nxt   = dbg_index;
          w_data_nxt   = dbg_data;
          w_byteen_nxt = dbg_byteen;
        end else if (w_grant_fifo) begin
          w_wren_nxt   = 1'b1;
          w_addr_nxt   = r_fifo_index[w_rd_addr];
          w_data_nxt   = r_fifo_data[w_rd_addr];
          w_byteen_nxt = r_fifo_byteen[w_rd_addr];
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_INIT;
      r_init_idx   <= '0;
      r_last_grant <= GRANT_FIFO;
      r_drop_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mem_wren   <= 1'b0;
      r_mem_wraddr <= '0;
      r_mem_data   <= '0;
      r_mem_byteen <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_init_idx   <= w_init_idx_nxt;
      r_mem_wren   <= w_wren_nxt;
      r_mem_wraddr <= w_addr_nxt;
      r_mem_data   <= w_data_nxt;
      r_mem_byteen <= w_byteen_nxt;

      if (w_tie) r_last_grant <= w_grant_dbg ? GRANT_DBG : GRANT_FIFO;

      if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok)    r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_grant_fifo) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; an entry is only ever read between
  // the pointers, which are reset, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo_index[w_wr_addr]  <= up_index;
      r_fifo_data[w_wr_addr]   <= up_data;
      r_fifo_byteen[w_wr_addr] <= up_byteen;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dbg_ready  = w_grant_dbg;
  assign init_busy  = (r_state == ST_INIT);
  assign mem_wren   = r_mem_wren;
  assign mem_wraddr = r_mem_wraddr;
  assign mem_data   = r_mem_data;
  assign mem_byteen = r_mem_byteen;
  assign drop_count = r_drop_count;

endmodule
